sc_dmem_arbiter: RTL and testbench

//  Shares the single-port data memory (and its memory-mapped I/O window) between two

---
 rtl/sc_dmem_arbiter_if.sv | 28 ++
 rtl/sc_dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_sc_dmem_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: one request/grant handshake
// plus its tagged read-return channel.
interface sc_dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  // Requester side: drives the access, receives grant and read data
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  // Arbiter side: samples the access, returns grant and read data
  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/sc_dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU (port C)
// and a debug/display loader (port D). One access per cycle, at most one read in
// flight per port, read data returned RD_LAT cycles later to the issuing port.
// RD_LAT is intended for the range 1..4.
module sc_dmem_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  sc_dmem_arbiter_if.slave c_port,
  sc_dmem_arbiter_if.slave d_port,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata
);

  localparam int unsigned LAST = RD_LAT - 1;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Last port granted; the other port wins the next tie
  owner_e last_win;

  // Read-return pipeline; pipe_owner bit is 1 when the read belongs to port D
  logic [RD_LAT-1:0] pipe_valid;
  logic [RD_LAT-1:0] pipe_owner;

  logic c_pending;
  logic d_pending;

  logic c_ret;
  logic d_ret;
  logic c_elig;
  logic d_elig;
  logic c_win;
  logic d_win;
  logic c_rd_grant;
  logic d_rd_grant;

  // Decode the read returning this cycle from the last pipeline stage
  always_comb begin
    c_ret = 1'b0;
    d_ret = 1'b0;
    if (!reset && pipe_valid[LAST]) begin
      if (pipe_owner[LAST]) begin
        d_ret = 1'b1;
      end else begin
        c_ret = 1'b1;
      end
    end
  end

  // Eligibility and round-robin winner selection
  always_comb begin
    // A returning read frees its port in the same cycle for back-to-back reads
    c_elig = !reset && c_port.req && (c_port.we || !c_pending || c_ret);
    d_elig = !reset && d_port.req && (d_port.we || !d_pending || d_ret);
    c_win  = c_elig && (!d_elig || (last_win == OWN_D));
    d_win  = d_elig && !c_win;
    c_rd_grant = c_win && !c_port.we;
    d_rd_grant = d_win && !d_port.we;
  end

  // Steer the winner onto the memory bus; idle bus is all zeros
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (c_win) begin
      mem_en    = 1'b1;
      mem_we    = c_port.we;
      mem_addr  = c_port.addr;
      mem_wdata = c_port.wdata;
    end else if (d_win) begin
      mem_en    = 1'b1;
      mem_we    = d_port.we;
      mem_addr  = d_port.addr;
      mem_wdata = d_port.wdata;
    end
  end

  // Grants and tagged read returns back to the requesters
  always_comb begin
    c_port.gnt    = c_win;
    c_port.rvalid = c_ret;
    c_port.rdata  = c_ret ? mem_rdata : '0;
    d_port.gnt    = d_win;
    d_port.rvalid = d_ret;
    d_port.rdata  = d_ret ? mem_rdata : '0;
  end

  // Arbitration history, read pipeline and per-port pending flags
  always_ff @(posedge clock) begin
    if (reset) begin
      last_win   <= OWN_D;
      pipe_valid <= '0;
      pipe_owner <= '0;
      c_pending  <= 1'b0;
      d_pending  <= 1'b0;
    end else begin
      if (c_win) begin
        last_win <= OWN_C;
      end else if (d_win) begin
        last_win <= OWN_D;
      end
      // Shift toward the last stage; the cast drops the bit leaving the pipe
      pipe_valid <= RD_LAT'({pipe_valid, c_rd_grant || d_rd_grant});
      pipe_owner <= RD_LAT'({pipe_owner, d_rd_grant});
      // A new read grant takes priority over the return clearing the flag
      c_pending  <= (c_pending && !c_ret) || c_rd_grant;
      d_pending  <= (d_pending && !d_ret) || d_rd_grant;
    end
  end

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// Directed bench for sc_dmem_arbiter at RD_LAT = 1, 2 and 3.
module tb_sc_dmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  // Expected control bits: {c_gnt, d_gnt, mem_en, mem_we, c_rvalid, d_rvalid}
  localparam logic [5:0] E_NONE = 6'b000000;
  localparam logic [5:0] E_CW   = 6'b101100;
  localparam logic [5:0] E_CR   = 6'b101000;
  localparam logic [5:0] E_DW   = 6'b011100;
  localparam logic [5:0] E_CRV  = 6'b000010;

  typedef struct {
    logic        rst;
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [5:0]  e_ctrl;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_crdata;
    logic [31:0] e_drdata;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  logic rst3 = 1'b1;

  sc_dmem_arbiter_if #(.AW(AW), .DW(DW)) c1 ();
  sc_dmem_arbiter_if #(.AW(AW), .DW(DW)) d1 ();
  sc_dmem_arbiter_if #(.AW(AW), .DW(DW)) c2 ();
  sc_dmem_arbiter_if #(.AW(AW), .DW(DW)) d2 ();
  sc_dmem_arbiter_if #(.AW(AW), .DW(DW)) c3 ();
  sc_dmem_arbiter_if #(.AW(AW), .DW(DW)) d3 ();

  logic        men1, mwe1, men2, mwe2, men3, mwe3;
  logic [31:0] maddr1, mwdata1, mrd1;
  logic [31:0] maddr2, mwdata2, mrd2;
  logic [31:0] maddr3, mwdata3, mrd3;

  sc_dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u1 (
    .clock(clk), .reset(rst1), .c_port(c1), .d_port(d1),
    .mem_en(men1), .mem_we(mwe1), .mem_addr(maddr1), .mem_wdata(mwdata1), .mem_rdata(mrd1)
  );
  sc_dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2)) u2 (
    .clock(clk), .reset(rst2), .c_port(c2), .d_port(d2),
    .mem_en(men2), .mem_we(mwe2), .mem_addr(maddr2), .mem_wdata(mwdata2), .mem_rdata(mrd2)
  );
  sc_dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) u3 (
    .clock(clk), .reset(rst3), .c_port(c3), .d_port(d3),
    .mem_en(men3), .mem_we(mwe3), .mem_addr(maddr3), .mem_wdata(mwdata3), .mem_rdata(mrd3)
  );

  // Small memories with a read-data delay line; tap selects the latency
  logic [31:0] marr1 [16];
  logic [31:0] marr2 [16];
  logic [31:0] marr3 [16];
  logic [31:0] dq1 [4];
  logic [31:0] dq2 [4];
  logic [31:0] dq3 [4];

  always_ff @(posedge clk) begin
    if (men1 && mwe1) marr1[maddr1[5:2]] <= mwdata1;
    if (men2 && mwe2) marr2[maddr2[5:2]] <= mwdata2;
    if (men3 && mwe3) marr3[maddr3[5:2]] <= mwdata3;
    dq1[0] <= marr1[maddr1[5:2]];
    dq2[0] <= marr2[maddr2[5:2]];
    dq3[0] <= marr3[maddr3[5:2]];
    for (int j = 1; j < 4; j++) begin
      dq1[j] <= dq1[j-1];
      dq2[j] <= dq2[j-1];
      dq3[j] <= dq3[j-1];
    end
  end

  assign mrd1 = dq1[0];
  assign mrd2 = dq2[1];
  assign mrd3 = dq3[2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rst,
    input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwdata,
    input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata,
    input logic [5:0] ectrl, input logic [31:0] eaddr, input logic [31:0] ewdata,
    input logic [31:0] ecr, input logic [31:0] edr);
    vec_t v;
    v.rst = rst;
    v.c_req = creq; v.c_we = cwe; v.c_addr = caddr; v.c_wdata = cwdata;
    v.d_req = dreq; v.d_we = dwe; v.d_addr = daddr; v.d_wdata = dwdata;
    v.e_ctrl = ectrl; v.e_addr = eaddr; v.e_wdata = ewdata;
    v.e_crdata = ecr; v.e_drdata = edr;
    return v;
  endfunction

  function automatic vec_t idle(input logic rst);
    return mk(rst, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
              E_NONE, 32'h0, 32'h0, 32'h0, 32'h0);
  endfunction

  task automatic run1(input vec_t v, input string name);
    @(negedge clk);
    rst1 = v.rst;
    c1.req = v.c_req; c1.we = v.c_we; c1.addr = v.c_addr; c1.wdata = v.c_wdata;
    d1.req = v.d_req; d1.we = v.d_we; d1.addr = v.d_addr; d1.wdata = v.d_wdata;
    #1;
    check({name, " ctrl"}, 128'({c1.gnt, d1.gnt, men1, mwe1, c1.rvalid, d1.rvalid}), 128'(v.e_ctrl));
    check({name, " bus"}, {maddr1, mwdata1, c1.rdata, d1.rdata},
          {v.e_addr, v.e_wdata, v.e_crdata, v.e_drdata});
  endtask

  task automatic run2(input vec_t v, input string name);
    @(negedge clk);
    rst2 = v.rst;
    c2.req = v.c_req; c2.we = v.c_we; c2.addr = v.c_addr; c2.wdata = v.c_wdata;
    d2.req = v.d_req; d2.we = v.d_we; d2.addr = v.d_addr; d2.wdata = v.d_wdata;
    #1;
    check({name, " ctrl"}, 128'({c2.gnt, d2.gnt, men2, mwe2, c2.rvalid, d2.rvalid}), 128'(v.e_ctrl));
    check({name, " bus"}, {maddr2, mwdata2, c2.rdata, d2.rdata},
          {v.e_addr, v.e_wdata, v.e_crdata, v.e_drdata});
  endtask

  task automatic run3(input vec_t v, input string name);
    @(negedge clk);
    rst3 = v.rst;
    c3.req = v.c_req; c3.we = v.c_we; c3.addr = v.c_addr; c3.wdata = v.c_wdata;
    d3.req = v.d_req; d3.we = v.d_we; d3.addr = v.d_addr; d3.wdata = v.d_wdata;
    #1;
    check({name, " ctrl"}, 128'({c3.gnt, d3.gnt, men3, mwe3, c3.rvalid, d3.rvalid}), 128'(v.e_ctrl));
    check({name, " bus"}, {maddr3, mwdata3, c3.rdata, d3.rdata},
          {v.e_addr, v.e_wdata, v.e_crdata, v.e_drdata});
  endtask

  vec_t tbl1 [17];

  initial begin
    c1.req = 1'b0; c1.we = 1'b0; c1.addr = '0; c1.wdata = '0;
    d1.req = 1'b0; d1.we = 1'b0; d1.addr = '0; d1.wdata = '0;
    c2.req = 1'b0; c2.we = 1'b0; c2.addr = '0; c2.wdata = '0;
    d2.req = 1'b0; d2.we = 1'b0; d2.addr = '0; d2.wdata = '0;
    c3.req = 1'b0; c3.we = 1'b0; c3.addr = '0; c3.wdata = '0;
    d3.req = 1'b0; d3.we = 1'b0; d3.addr = '0; d3.wdata = '0;

    // RD_LAT=1: reset gating, single write/read, alternating ties, read interplay
    tbl1[0]  = mk(1, 1, 1, 32'h10, 32'hDEADBEEF, 1, 0, 32'h20, 32'h0,
                  E_NONE, 32'h0, 32'h0, 32'h0, 32'h0);
    tbl1[1]  = mk(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0,
                  E_CW, 32'h10, 32'hDEADBEEF, 32'h0, 32'h0);
    tbl1[2]  = idle(0);
    tbl1[3]  = mk(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0,
                  E_CR, 32'h10, 32'h0, 32'h0, 32'h0);
    tbl1[4]  = mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
                  E_CRV, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0);
    tbl1[5]  = idle(0);
    tbl1[6]  = idle(1);
    for (int i = 7; i <= 12; i++) begin
      if ((i % 2) == 1)
        tbl1[i] = mk(0, 1, 1, 32'h20, 32'hC0C0C0C0, 1, 1, 32'h30, 32'hD0D0D0D0,
                     E_CW, 32'h20, 32'hC0C0C0C0, 32'h0, 32'h0);
      else
        tbl1[i] = mk(0, 1, 1, 32'h20, 32'hC0C0C0C0, 1, 1, 32'h30, 32'hD0D0D0D0,
                     E_DW, 32'h30, 32'hD0D0D0D0, 32'h0, 32'h0);
    end
    tbl1[13] = mk(0, 1, 0, 32'h20, 32'h0, 1, 0, 32'h30, 32'h0,
                  E_CR, 32'h20, 32'h0, 32'h0, 32'h0);
    tbl1[14] = mk(0, 1, 0, 32'h20, 32'h0, 1, 0, 32'h30, 32'h0,
                  6'b011010, 32'h30, 32'h0, 32'hC0C0C0C0, 32'h0);
    tbl1[15] = mk(0, 1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0,
                  6'b101001, 32'h20, 32'h0, 32'h0, 32'hD0D0D0D0);
    tbl1[16] = mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
                  E_CRV, 32'h0, 32'h0, 32'hC0C0C0C0, 32'h0);

    for (int i = 0; i < 17; i++) begin
      run1(tbl1[i], $sformatf("lat1 v%0d", i));
    end
    run1(idle(0), "lat1 tail");

    // RD_LAT=2: write overlapping a pending read, then reset mid-read
    run2(idle(1), "lat2 reset");
    run2(mk(0, 1, 1, 32'h50, 32'hCAFEF00D, 0, 0, 32'h0, 32'h0,
            E_CW, 32'h50, 32'hCAFEF00D, 32'h0, 32'h0), "lat2 c write");
    run2(mk(0, 1, 0, 32'h50, 32'h0, 0, 0, 32'h0, 32'h0,
            E_CR, 32'h50, 32'h0, 32'h0, 32'h0), "lat2 c read");
    run2(mk(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h60, 32'h0BADC0DE,
            E_DW, 32'h60, 32'h0BADC0DE, 32'h0, 32'h0), "lat2 d write under read");
    run2(mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
            E_CRV, 32'h0, 32'h0, 32'hCAFEF00D, 32'h0), "lat2 c return");
    run2(mk(0, 1, 0, 32'h50, 32'h0, 0, 0, 32'h0, 32'h0,
            E_CR, 32'h50, 32'h0, 32'h0, 32'h0), "lat2 read before reset");
    run2(mk(1, 1, 0, 32'h50, 32'h0, 1, 1, 32'h60, 32'h0,
            E_NONE, 32'h0, 32'h0, 32'h0, 32'h0), "lat2 in reset");
    for (int i = 2; i <= 4; i++) begin
      run2(idle(0), $sformatf("lat2 no return c%0d", i));
    end
    run2(mk(0, 1, 1, 32'h50, 32'h11111111, 1, 1, 32'h60, 32'h22222222,
            E_CW, 32'h50, 32'h11111111, 32'h0, 32'h0), "lat2 tie after reset");
    run2(mk(0, 1, 0, 32'h50, 32'h0, 0, 0, 32'h0, 32'h0,
            E_CR, 32'h50, 32'h0, 32'h0, 32'h0), "lat2 pending cleared");
    run2(idle(0), "lat2 wait");
    run2(mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
            E_CRV, 32'h0, 32'h0, 32'h11111111, 32'h0), "lat2 return after reset");

    // RD_LAT=3: second read blocked until the first returns
    run3(idle(1), "lat3 reset");
    run3(mk(0, 1, 1, 32'h40, 32'h12345678, 0, 0, 32'h0, 32'h0,
            E_CW, 32'h40, 32'h12345678, 32'h0, 32'h0), "lat3 c write");
    run3(mk(0, 1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0,
            E_CR, 32'h40, 32'h0, 32'h0, 32'h0), "lat3 read c0");
    for (int i = 1; i <= 2; i++) begin
      run3(mk(0, 1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0,
              E_NONE, 32'h0, 32'h0, 32'h0, 32'h0), $sformatf("lat3 blocked c%0d", i));
    end
    run3(mk(0, 1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0,
            6'b101010, 32'h40, 32'h0, 32'h12345678, 32'h0), "lat3 return and reissue c3");
    for (int i = 4; i <= 5; i++) begin
      run3(idle(0), $sformatf("lat3 idle c%0d", i));
    end
    run3(mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
            E_CRV, 32'h0, 32'h0, 32'h12345678, 32'h0), "lat3 second return c6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
